branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Control-flow resolution unit at the opposite end of the program counter's jump interface.
- Accepts resolved branch/jump instructions from decode, each tagged with the address the PC reported for it.
- Evaluates the branch condition and computes the target word address.
- Drives the PC's Jump/JumpTo inputs, kills wrong-path instructions already fetched, and supplies the link address for JAL/JALR writeback.

Parameters:
- XLEN, 32, operand width for comparisons
- AW, 10, instruction word-address width (matches PC)
- FLUSH_CYCLES, 2, number of cycles kill is asserted per redirect (>=1)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- br_valid  in  1  instruction in br_* is a branch/jump to resolve this cycle
- br_op  in  3  000 BEQ, 001 BNE, 010 JAL, 011 JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- br_pc  in  AW  word address of the instruction (PC's Previous output)
- rs1_val  in  XLEN  source operand 1
- rs2_val  in  XLEN  source operand 2
- imm  in  12  signed offset in words
- stat_clr  in  1  synchronous clear of statistics counters
- Jump  out  1  redirect request to PC, one-cycle pulse
- JumpTo  out  AW  redirect target
- kill  out  1  squash the instruction currently in decode (wrong path)
- link_valid  out  1  link_addr valid for register writeback
- link_addr  out  AW  br_pc+1 of the JAL/JALR being redirected
- branch_cnt  out  CNT_W  accepted branch/jump count, saturating
- taken_cnt  out  CNT_W  taken branch/jump count, saturating

Behaviour:
- Reset (Reset_n=0, async):
  - All outputs 0; FSM to IDLE; flush counter 0.
  - Applies immediately, including mid-redirect or mid-flush: Jump and kill drop without waiting for a clock.
- Accept: br_valid=1 while FSM=IDLE. In REDIRECT/FLUSH br_valid is a wrong-path instruction: ignored, not counted, no state change.
- Condition:
  - BEQ rs1==rs2; BNE rs1!=rs2.
  - BLT/BGE: signed XLEN compare. BLTU/BGEU: unsigned.
  - JAL/JALR always taken.
- Target arithmetic: imm sign-extended, then truncated to AW bits; all sums are modulo 2^AW (wrap, no error flag).
  - Branches and JAL: br_pc + imm.
  - JALR: rs1_val[AW-1:0] + imm.
- Link: br_pc + 1 modulo 2^AW.
- FSM states:
  - IDLE: accepted and taken -> REDIRECT; accepted not taken -> stay IDLE, no outputs.
  - REDIRECT (one cycle):
    - Jump=1, JumpTo=target, kill=1.
    - link_valid=1 and link_addr set only for JAL/JALR.
    - If FLUSH_CYCLES==1 -> IDLE; else load counter FLUSH_CYCLES-2 -> FLUSH.
  - FLUSH: kill=1, Jump=0, link_valid=0; decrement counter each cycle; at 0 -> IDLE.
- Latency: Jump asserted the cycle after the accepting edge (all control outputs registered). kill is high for exactly FLUSH_CYCLES consecutive cycles starting with the Jump cycle.
- Back-to-back: a taken branch in the first IDLE cycle after FLUSH is accepted normally.
- JumpTo and link_addr hold their last value when not asserted; reset value 0.
- Counters:
  - branch_cnt increments on every accept; taken_cnt on every taken accept.
  - Both saturate at 2^CNT_W-1.
  - stat_clr has priority over increment in the same cycle.

Decomposition:
- Shared package holds:
  - br_op encodings as named constants;
  - FSM state typedef {IDLE, REDIRECT, FLUSH};
  - default AW/XLEN constants shared with the PC.
- One natural sub-module: br_compare (combinational condition evaluation from br_op, rs1_val, rs2_val). Counters and FSM stay in the top.

Test Plan:
- BEQ, rs1=rs2=5, br_pc=100, imm=-4 -> next cycle Jump=1, JumpTo=96, kill=1 for 2 cycles, link_valid=0; branch_cnt=1, taken_cnt=1.
- BNE, rs1=rs2=7 -> no Jump, no kill; branch_cnt increments, taken_cnt unchanged.
- JAL, br_pc=1020, imm=8 -> JumpTo=4 (wrap); link_valid=1, link_addr=1021. JALR, rs1=0x205, imm=3 -> JumpTo=0x208.
- rs1=0xFFFFFFFF, rs2=1: BLT -> taken; BLTU -> not taken. BGE/BGEU -> opposite results.
- Taken BEQ followed by br_valid on each of the 2 kill cycles -> both ignored, no second Jump, branch_cnt +1 only. Reset_n pulsed low during FLUSH -> kill=0 immediately, FSM IDLE.
- Force counters to 0xFFFF, issue taken branch -> stay 0xFFFF. stat_clr together with an accept -> counters read 0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch resolution: opcode encodings, FSM states, default widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package branch_resolve_pkg;

    // Widths shared with the program counter block
    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 10;

    // br_op encodings
    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_JAL  = 3'b010;
    localparam logic [2:0] OP_JALR = 3'b011;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // Jumps that write a return address back to the register file
    function automatic logic is_link_op(input logic [2:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve_br_compare.sv
// Branch condition evaluation from opcode and the two source operands.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module branch_resolve_br_compare
    import branch_resolve_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (i_rs1 == i_rs2);
    assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u = (i_rs1 < i_rs2);

    // Select the comparison the opcode asks for; jumps are unconditional
    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            OP_BEQ:  o_taken = w_eq;
            OP_BNE:  o_taken = !w_eq;
            OP_JAL:  o_taken = 1'b1;
            OP_JALR: o_taken = 1'b1;
            OP_BLT:  o_taken = w_lt_s;
            OP_BGE:  o_taken = !w_lt_s;
            OP_BLTU: o_taken = w_lt_u;
            OP_BGEU: o_taken = !w_lt_u;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches/jumps: drives PC redirect, kills wrong-path decode, supplies link address.
// Latency: Jump/kill one cycle after the accepting edge; kill held FLUSH_CYCLES cycles.
// Backpressure: none; br_valid seen while redirecting/flushing is wrong-path and dropped.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int AW           = AW_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic [AW-1:0]    br_pc,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [11:0]      imm,
    input  logic             stat_clr,
    output logic             Jump,
    output logic [AW-1:0]    JumpTo,
    output logic             kill,
    output logic             link_valid,
    output logic [AW-1:0]    link_addr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Flush counter counts down the kill cycles left after the redirect cycle
    localparam int FW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FW'(FLUSH_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [FW-1:0]    r_flush_cnt;
    logic             r_jump;
    logic [AW-1:0]    r_jump_to;
    logic             r_kill;
    logic             r_link_vld;
    logic [AW-1:0]    r_link_addr;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_taken;
    logic             w_accept;
    logic [AW-1:0]    w_imm_aw;
    logic [AW-1:0]    w_base;
    logic [AW-1:0]    w_target;
    logic [AW-1:0]    w_link;

    branch_resolve_br_compare #(
        .XLEN (XLEN)
    ) u_br_compare (
        .i_op    (br_op),
        .i_rs1   (rs1_val),
        .i_rs2   (rs2_val),
        .o_taken (w_taken)
    );

    // Only the idle state can take a new instruction; everything else is wrong-path
    assign w_accept = br_valid && (r_state == ST_IDLE);

    // Offset is sign-extended then truncated, so all target sums wrap modulo 2^AW
    assign w_imm_aw = AW'($signed(imm));
    assign w_base   = (br_op == OP_JALR) ? rs1_val[AW-1:0] : br_pc;
    assign w_target = w_base + w_imm_aw;
    assign w_link   = br_pc + AW'(1);

    // Redirect/flush sequencer with all control outputs registered
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_jump      <= 1'b0;
            r_jump_to   <= '0;
            r_kill      <= 1'b0;
            r_link_vld  <= 1'b0;
            r_link_addr <= '0;
        end else begin
            r_jump     <= 1'b0;
            r_link_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_taken) begin
                        r_state   <= ST_REDIRECT;
                        r_jump    <= 1'b1;
                        r_jump_to <= w_target;
                        r_kill    <= 1'b1;
                        if (is_link_op(br_op)) begin
                            r_link_vld  <= 1'b1;
                            r_link_addr <= w_link;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (FLUSH_CYCLES == 1) begin
                        r_state <= ST_IDLE;
                        r_kill  <= 1'b0;
                    end else begin
                        r_flush_cnt <= FLUSH_LOAD;
                        r_state     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_kill  <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (stat_clr) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (w_accept) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_taken && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign Jump       = r_jump;
    assign JumpTo     = r_jump_to;
    assign kill       = r_kill;
    assign link_valid = r_link_vld;
    assign link_addr  = r_link_addr;
    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table, corner sequences, random vs reference model.
// Latency: checks one cycle after each driving edge.
// Backpressure: models wrong-path drops during the kill window.
module tb_branch_resolve;

    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int FC    = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int AMOD  = 1 << AW;

    logic             clk = 1'b0;
    logic             Reset_n;
    logic             br_valid;
    logic [2:0]       br_op;
    logic [AW-1:0]    br_pc;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [11:0]      imm;
    logic             stat_clr;
    logic             Jump;
    logic [AW-1:0]    JumpTo;
    logic             kill;
    logic             link_valid;
    logic [AW-1:0]    link_addr;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_resolve #(
        .XLEN(XLEN), .AW(AW), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .Reset_n(Reset_n), .br_valid(br_valid), .br_op(br_op),
        .br_pc(br_pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .stat_clr(stat_clr), .Jump(Jump), .JumpTo(JumpTo), .kill(kill),
        .link_valid(link_valid), .link_addr(link_addr),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: kill cycles still owed, expected registered outputs
    int   m_busy;
    int   m_bc;
    int   m_tc;
    logic m_jump;
    logic m_lv;
    int   m_jt;
    int   m_la;

    function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2, 3'd3: return 1'b1;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic int ref_target(input logic [2:0] op, input logic [9:0] pc,
                                      input logic [31:0] a, input logic [11:0] im);
        int base = (op == 3'd3) ? int'(a[9:0]) : int'(pc);
        int off  = int'($signed(im));
        return ((base + off) % AMOD + AMOD) % AMOD;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_bc = 0; m_tc = 0; m_jump = 0; m_lv = 0; m_jt = 0; m_la = 0;
    endtask

    task automatic model_step();
        logic t;
        m_jump = 0;
        m_lv   = 0;
        if (m_busy > 0) begin
            m_busy--;
        end else if (br_valid) begin
            t = ref_taken(br_op, rs1_val, rs2_val);
            if (m_bc < CMAX) m_bc++;
            if (t && m_tc < CMAX) m_tc++;
            if (t) begin
                m_busy = FC;
                m_jump = 1;
                m_jt   = ref_target(br_op, br_pc, rs1_val, imm);
                if (br_op == 3'd2 || br_op == 3'd3) begin
                    m_lv = 1;
                    m_la = (int'(br_pc) + 1) % AMOD;
                end
            end
        end
        if (stat_clr) begin
            m_bc = 0;
            m_tc = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("jump",       32'(Jump),       32'(m_jump));
        chk("kill",       32'(kill),       32'(m_busy > 0));
        chk("jump_to",    32'(JumpTo),     32'(m_jt));
        chk("link_valid", 32'(link_valid), 32'(m_lv));
        chk("link_addr",  32'(link_addr),  32'(m_la));
        chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
        chk("taken_cnt",  32'(taken_cnt),  32'(m_tc));
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [9:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] im, input logic clr);
        br_valid = v; br_op = op; br_pc = pc; rs1_val = a; rs2_val = b; imm = im; stat_clr = clr;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 10'd0, 32'd0, 32'd0, 12'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [9:0]  pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm;
        logic        taken;
        logic [9:0]  target;
        logic        lv;
        logic [9:0]  link;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'd0, 10'd100,  32'd5,          32'd5, 12'hFFC, 1'b1, 10'd96,  1'b0, 10'd0};
        tbl[1] = '{3'd1, 10'd100,  32'd7,          32'd7, 12'h004, 1'b0, 10'd0,   1'b0, 10'd0};
        tbl[2] = '{3'd2, 10'd1020, 32'd0,          32'd0, 12'h008, 1'b1, 10'd4,   1'b1, 10'd1021};
        tbl[3] = '{3'd3, 10'd50,   32'h205,        32'd0, 12'h003, 1'b1, 10'h208, 1'b1, 10'd51};
        tbl[4] = '{3'd4, 10'd200,  32'hFFFF_FFFF,  32'd1, 12'h005, 1'b1, 10'd205, 1'b0, 10'd0};
        tbl[5] = '{3'd6, 10'd200,  32'hFFFF_FFFF,  32'd1, 12'h005, 1'b0, 10'd0,   1'b0, 10'd0};
        tbl[6] = '{3'd5, 10'd200,  32'hFFFF_FFFF,  32'd1, 12'h005, 1'b0, 10'd0,   1'b0, 10'd0};
        tbl[7] = '{3'd7, 10'd200,  32'hFFFF_FFFF,  32'd1, 12'hED4, 1'b1, 10'd924, 1'b0, 10'd0};
        tbl[8] = '{3'd0, 10'd10,   32'd3,          32'd4, 12'h001, 1'b0, 10'd0,   1'b0, 10'd0};
        tbl[9] = '{3'd1, 10'd0,    32'd3,          32'd4, 12'hFFF, 1'b1, 10'd1023, 1'b0, 10'd0};

        Reset_n = 1'b0;
        idle();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        Reset_n = 1'b1;

        // Directed table: each vector from idle, then drain the kill window
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b0);
            step();
            chk("tbl_jump", 32'(Jump), 32'(tbl[i].taken));
            chk("tbl_kill", 32'(kill), 32'(tbl[i].taken));
            if (tbl[i].taken) begin
                chk("tbl_jump_to",    32'(JumpTo),     32'(tbl[i].target));
                chk("tbl_link_valid", 32'(link_valid), 32'(tbl[i].lv));
                if (tbl[i].lv) chk("tbl_link_addr", 32'(link_addr), 32'(tbl[i].link));
            end
            idle();
            for (int k = 0; k < 3; k++) step();
        end

        // Wrong-path br_valid during both kill cycles, then back-to-back accept
        begin
            int pre_bc;
            pre_bc = m_bc;
            drive(1'b1, 3'd0, 10'd300, 32'd9, 32'd9, 12'h010, 1'b0);
            step();
            chk("wp_first_jump", 32'(Jump), 32'd1);
            step();
            chk("wp_jump_1", 32'(Jump), 32'd0);
            chk("wp_kill_1", 32'(kill), 32'd1);
            step();
            chk("wp_jump_2", 32'(Jump), 32'd0);
            chk("wp_kill_2", 32'(kill), 32'd0);
            chk("wp_branch_cnt", 32'(branch_cnt), 32'(pre_bc + 1));
            drive(1'b1, 3'd1, 10'd40, 32'd1, 32'd2, 12'h002, 1'b0);
            step();
            chk("b2b_jump", 32'(Jump), 32'd1);
            chk("b2b_jump_to", 32'(JumpTo), 32'd42);
            idle();
            for (int k = 0; k < 2; k++) step();
        end

        // Asynchronous reset while flushing
        drive(1'b1, 3'd2, 10'd7, 32'd0, 32'd0, 12'h001, 1'b0);
        step();
        idle();
        step();
        chk("pre_rst_kill", 32'(kill), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_kill", 32'(kill), 32'd0);
        chk("rst_jump", 32'(Jump), 32'd0);
        chk("rst_link_addr", 32'(link_addr), 32'd0);
        chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
        @(negedge clk);
        Reset_n = 1'b1;
        drive(1'b1, 3'd0, 10'd5, 32'd1, 32'd1, 12'h001, 1'b0);
        step();
        chk("post_rst_jump", 32'(Jump), 32'd1);
        idle();
        for (int k = 0; k < 2; k++) step();

        // Saturation of both counters
        for (int i = 0; i < CMAX + 5; i++) begin
            drive(1'b1, 3'd0, 10'(i), 32'd1, 32'd1, 12'h001, 1'b0);
            step();
            idle();
            step();
            step();
        end
        chk("sat_branch_cnt", 32'(branch_cnt), 32'(CMAX));
        chk("sat_taken_cnt",  32'(taken_cnt),  32'(CMAX));

        // Clear beats a same-cycle increment
        drive(1'b1, 3'd0, 10'd1, 32'd1, 32'd1, 12'h001, 1'b1);
        step();
        chk("clr_branch_cnt", 32'(branch_cnt), 32'd0);
        chk("clr_taken_cnt",  32'(taken_cnt),  32'd0);
        idle();
        for (int k = 0; k < 2; k++) step();

        // Random traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom());
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3)) - 32'd2;
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom()),
                  a, b, 12'($urandom()), 1'($urandom_range(0, 40) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
